// File: rtl/eeprom_slave.sv
// eeprom_slave: I2C serial EEPROM slave (24Cxx-style) with a 2**MEM_AW byte array.
// SCL/SDA are synchronised into the clk domain; bits are sampled on synchronised
// SCL rising edges and SDA is only changed on synchronised SCL falling edges.
// dbg_state exposes the FSM state encoding (0 = IDLE) for checkers.
// Optional write protection: define EEPROM_SLAVE_WP_EN to add the wp input.
module eeprom_slave #(
    parameter logic [3:0] DEV_ID = 4'b1010,
    parameter int         MEM_AW = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
`ifdef EEPROM_SLAVE_WP_EN
    input  logic       wp,
`endif
    output logic       busy,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CTRL      = 4'd1,
        ACK_CTRL  = 4'd2,
        ADDR      = 4'd3,
        ACK_ADDR  = 4'd4,
        WDATA     = 4'd5,
        ACK_WDATA = 4'd6,
        RDATA     = 4'd7,
        MACK      = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    state_t              state;
    logic [1:0]          scl_sync, sda_sync;
    logic                scl_d, sda_d;
    logic                scl_s, sda_s;
    logic                scl_rise, scl_fall, start_det, stop_det;
    logic                sda_oe;
    logic [MEM_AW-1:0]   ptr;
    logic [3:0]          bit_cnt;
    logic [7:0]          shift;
    logic [6:0]          tx;
    logic [2:0]          hi_bits;
    logic                rw, mack_ok, wr_blk, wp_active;
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_waddr;
    logic [7:0]          mem_wdata;
    logic [7:0]          mem [0:(2**MEM_AW)-1];

`ifdef EEPROM_SLAVE_WP_EN
    assign wp_active = wp;
`else
    assign wp_active = 1'b0;
`endif

    // Open drain: only ever pull low; reset releases the line without waiting for clk.
    assign sda = (sda_oe && !reset) ? 1'b0 : 1'bz;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign dbg_state = state;

    // Two-flop synchronisers plus one delayed copy for edge/condition detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    // Byte array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Protocol FSM: START/STOP override every state, otherwise per-state bit handling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            sda_oe    <= 1'b0;
            ptr       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            tx        <= '0;
            hi_bits   <= '0;
            rw        <= 1'b0;
            mack_ok   <= 1'b0;
            wr_blk    <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_det) begin
                state   <= CTRL;
                bit_cnt <= '0;
                busy    <= 1'b1;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= '0;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    CTRL, ADDR, WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == CTRL) begin
                                if (shift[7:4] == DEV_ID) begin
                                    sda_oe  <= 1'b1;
                                    rw      <= shift[0];
                                    hi_bits <= shift[3:1];
                                    state   <= ACK_CTRL;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= WAIT_STOP;
                                end
                            end else if (state == ADDR) begin
                                ptr[7:0] <= shift;
                                sda_oe   <= 1'b1;
                                state    <= ACK_ADDR;
                            end else begin
                                // Write-protected bytes are NACKed instead of ACKed.
                                sda_oe <= ~wp_active;
                                wr_blk <= wp_active;
                                state  <= ACK_WDATA;
                            end
                        end
                    end
                    ACK_CTRL: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (!rw) begin
                                ptr[MEM_AW-1:8] <= hi_bits[MEM_AW-9:0];
                                sda_oe          <= 1'b0;
                                state           <= ADDR;
                            end else begin
                                // Reads start at the current pointer; the block bits are ignored.
                                tx     <= mem[ptr][6:0];
                                sda_oe <= ~mem[ptr][7];
                                state  <= RDATA;
                            end
                        end
                    end
                    ACK_ADDR: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= WDATA;
                        end
                    end
                    ACK_WDATA: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            if (wr_blk) begin
                                state <= WAIT_STOP;
                            end else begin
                                mem_we    <= 1'b1;
                                mem_waddr <= ptr;
                                mem_wdata <= shift;
                                ptr       <= ptr + 1'b1;
                                state     <= WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= MACK;
                            end else begin
                                sda_oe <= ~tx[6];
                                tx     <= {tx[5:0], 1'b0};
                            end
                        end
                    end
                    MACK: begin
                        if (scl_rise) begin
                            mack_ok <= ~sda_s;
                            if (!sda_s)
                                ptr <= ptr + 1'b1;
                        end else if (scl_fall) begin
                            if (mack_ok) begin
                                tx     <= mem[ptr][6:0];
                                sda_oe <= ~mem[ptr][7];
                                state  <= RDATA;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eeprom_slave.sv
// tb_eeprom_slave: bit-banged I2C master driving eeprom_slave, checked against a
// byte-array/pointer model of the EEPROM. Directed scenarios followed by random
// write/readback transactions.
module tb_eeprom_slave;

    localparam int Q = 40;  // quarter SCL period in ns (clk period 10 ns)

    logic       clk;
    logic       reset;
    logic       scl;
    logic       sda_low;
    logic       busy;
    logic [3:0] dbg_state;
    wire        sda;
`ifdef EEPROM_SLAVE_WP_EN
    logic       wp;
`endif

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    eeprom_slave dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
`ifdef EEPROM_SLAVE_WP_EN
        .wp        (wp),
`endif
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model: byte array plus address pointer, following the protocol rules.
    logic [7:0]  model_mem [0:2047];
    logic [10:0] model_ptr;
    logic [7:0]  exp_q [$];
    logic [7:0]  wbuf [0:7];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_byte(input logic [10:0] a, input logic rd);
        return {4'b1010, a[10:8], rd};
    endfunction

    // Bit-level master drivers
    task automatic i2c_start();
        sda_low = 1'b0;
        #Q; scl = 1'b1;
        #(2*Q); sda_low = 1'b1;
        #(2*Q); scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        #Q; scl = 1'b1;
        #(2*Q); sda_low = 1'b0;
        #(2*Q);
    endtask

    task automatic write_bit(input logic b);
        sda_low = ~b;
        #Q; scl = 1'b1;
        #(2*Q); scl = 1'b0;
        #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_low = 1'b0;
        #Q; scl = 1'b1;
        #Q; b = sda;
        #Q; scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic i2c_read_byte(input logic send_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~send_ack);
    endtask

    // Transaction-level helpers that also advance the model
    task automatic do_write(input logic [10:0] a, input int n, input string tag);
        logic ack;
        i2c_start();
        i2c_write_byte(ctrl_byte(a, 1'b0), ack);
        check({tag, "_ctrl_ack"}, ack, 1'b1);
        i2c_write_byte(a[7:0], ack);
        check({tag, "_addr_ack"}, ack, 1'b1);
        model_ptr = a;
        for (int i = 0; i < n; i++) begin
            i2c_write_byte(wbuf[i], ack);
            check({tag, "_data_ack"}, ack, 1'b1);
            model_mem[model_ptr] = wbuf[i];
            model_ptr = model_ptr + 11'd1;
        end
        i2c_stop();
    endtask

    task automatic do_read(input logic [10:0] a, input int n, input logic set_ptr, input string tag);
        logic       ack;
        logic [7:0] d;
        if (set_ptr) begin
            i2c_start();
            i2c_write_byte(ctrl_byte(a, 1'b0), ack);
            check({tag, "_wctrl_ack"}, ack, 1'b1);
            i2c_write_byte(a[7:0], ack);
            check({tag, "_addr_ack"}, ack, 1'b1);
            model_ptr = a;
        end
        i2c_start();
        i2c_write_byte(ctrl_byte(a, 1'b1), ack);
        check({tag, "_rctrl_ack"}, ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_mem[model_ptr]);
            i2c_read_byte(i < n - 1, d);
            check({tag, "_rdata"}, d, exp_q.pop_front());
            if (i < n - 1) model_ptr = model_ptr + 11'd1;
        end
        i2c_stop();
        #(4*Q);
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_sda_rel"}, sda, 1'b1);
    endtask

    // Main sequence
    initial begin : main
        logic       ack;
        logic [7:0] d;
        logic [10:0] a;
        int         n, k;

        reset = 1'b1;
        scl = 1'b1;
        sda_low = 1'b0;
`ifdef EEPROM_SLAVE_WP_EN
        wp = 1'b0;
`endif
        model_ptr = '0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, 4'd0);
        check("rst_sda", sda, 1'b1);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // Byte write then random read through a repeated START
        wbuf[0] = 8'hA5;
        do_write(11'h123, 1, "bw");
        do_read(11'h123, 1, 1'b1, "rr");

        // Wrong device type: no ACK, following bytes ignored
        i2c_start();
        #Q;
        check("wd_busy_start", busy, 1'b1);
        i2c_write_byte(8'hB0, ack);
        check("wd_ctrl_nack", ack, 1'b0);
        i2c_write_byte(8'h00, ack);
        check("wd_byte_nack", ack, 1'b0);
        check("wd_busy_mid", busy, 1'b1);
        i2c_stop();
        #(2*Q);
        check("wd_busy_end", busy, 1'b0);

        // Sequential write and read across the top-of-array wrap
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        do_write(11'h7FF, 2, "wrapw");
        do_read(11'h7FF, 2, 1'b1, "wrapr");

        // STOP in the middle of a data byte aborts it
        wbuf[0] = 8'h5A;
        do_write(11'h010, 1, "abw");
        i2c_start();
        i2c_write_byte(ctrl_byte(11'h010, 1'b0), ack);
        check("ab_ctrl_ack", ack, 1'b1);
        i2c_write_byte(8'h10, ack);
        check("ab_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop();
        #(2*Q);
        check("ab_state", dbg_state, 4'd0);
        check("ab_busy", busy, 1'b0);
        do_read(11'h010, 1, 1'b1, "abr");

        // Reset while the slave is driving a 0 data bit
        i2c_start();
        i2c_write_byte(ctrl_byte(11'h010, 1'b0), ack);
        check("rm_ctrl_ack", ack, 1'b1);
        i2c_write_byte(8'h10, ack);
        check("rm_addr_ack", ack, 1'b1);
        i2c_start();
        i2c_write_byte(ctrl_byte(11'h010, 1'b1), ack);
        check("rm_rctrl_ack", ack, 1'b1);
        check("rm_drive0", sda, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rm_sda_async", sda, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("rm_busy", busy, 1'b0);
        check("rm_state", dbg_state, 4'd0);
        scl = 1'b1;
        sda_low = 1'b0;
        #Q;
        reset = 1'b0;
        model_ptr = '0;
        repeat (5) @(posedge clk);
        do_read(11'h000, 1, 1'b0, "rm_cur");

`ifdef EEPROM_SLAVE_WP_EN
        // Write protection: data byte NACKed and memory unchanged
        wbuf[0] = 8'h3C;
        do_write(11'h040, 1, "wp_pre");
        wp = 1'b1;
        i2c_start();
        i2c_write_byte(ctrl_byte(11'h040, 1'b0), ack);
        check("wp_ctrl_ack", ack, 1'b1);
        i2c_write_byte(8'h40, ack);
        check("wp_addr_ack", ack, 1'b1);
        i2c_write_byte(8'hFF, ack);
        check("wp_data_nack", ack, 1'b0);
        i2c_stop();
        wp = 1'b0;
        do_read(11'h040, 1, 1'b1, "wp_rd");
`endif

        // Random writes with readback from a random offset inside the written run
        for (int it = 0; it < 8; it++) begin
            a = 11'($urandom_range(0, 2047));
            if (it == 0) a = 11'h7FE;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(a, n, "rnd_w");
            k = $urandom_range(0, n - 1);
            do_read(a + 11'(k), n - k, 1'b1, "rnd_r");
            if ($urandom_range(0, 1) == 1)
                do_read(11'h000, 1, 1'b0, "rnd_cur");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eeprom_slave.md
EEPROM_SLAVE -- requirements
Module: eeprom_slave

Interface
REQ-001 Parameter DEV_ID, default 4'b1010, is the device-type nibble matched against control-byte bits [7:4].
REQ-002 Parameter MEM_AW, default 11, is the memory address width; depth is 2**MEM_AW bytes.
REQ-003 CLK  input  1  system clock; all sequential logic samples on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 SCL  input  1  I2C serial clock from the master; asynchronous to CLK.
REQ-006 SDA  inout  1  I2C data line, open-drain: the block drives 1'b0 or releases to 1'bz, and never drives 1.
REQ-007 BUSY  output  1  high from a detected START until the next detected STOP.

Function
REQ-008 SCL and SDA shall each pass through a 2-flop synchroniser before use; CLK frequency is at least 10x SCL frequency.
REQ-009 START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are detected in any state, including mid-byte.
REQ-010 Bits shall be sampled on a synchronised SCL rising edge, MSB first; SDA output changes only on a synchronised SCL falling edge.
REQ-011 The FSM states are IDLE, CTRL, ACK_CTRL, ADDR, ACK_ADDR, WDATA, ACK_WDATA, RDATA, MACK and WAIT_STOP.
REQ-012 START, from any state: go to CTRL, clear the bit counter and set BUSY. STOP, from any state: go to IDLE, release SDA and clear BUSY.
REQ-013 CTRL shall shift in 8 bits: DEV_ID[3:0], A[10:8] (upper pointer bits, truncated to MEM_AW-8 bits), then R/W.
REQ-014 If the nibble equals DEV_ID, go to ACK_CTRL and pull SDA low for the 9th SCL pulse; otherwise release SDA and go to WAIT_STOP.
REQ-015 After ACK_CTRL with R/W=0: load pointer bits A[10:8], then go to ADDR.
REQ-016 After ACK_CTRL with R/W=1: keep the pointer, present mem[pointer] MSB first in RDATA, and ignore the A[10:8] field.
REQ-017 ADDR shall shift in pointer bits A[7:0], then ACK in ACK_ADDR, then go to WDATA.
REQ-018 WDATA shall shift in 8 bits, then ACK in ACK_WDATA.
REQ-019 On the SCL falling edge ending ACK_WDATA: write the byte to mem[pointer], increment the pointer, then return to WDATA.
REQ-020 After RDATA's 8th bit, release SDA in MACK. If the master drives SDA=0 at SCL rise: increment the pointer and send the next byte. If SDA=1 (NACK): go to WAIT_STOP.
REQ-021 The pointer shall be MEM_AW bits wide and wrap from 2**MEM_AW-1 to 0 for both reads and writes.
REQ-022 A repeated START after ADDR keeps the loaded pointer; this is how a random read works.
REQ-023 A START or STOP arriving mid-byte shall abort the partial byte with no memory write.
REQ-024 In WAIT_STOP, SDA shall stay released and all bits are ignored until START or STOP.

Reset
REQ-025 While RESET=1: state=IDLE, SDA released (z), BUSY=0, pointer=0, bit counter=0, synchronisers at 1.
REQ-026 Memory contents are not reset and persist across RESET.
REQ-027 Assertion of RESET mid-transfer shall release SDA immediately and take effect asynchronously, without waiting for a CLK edge.

Configuration
REQ-028 The macro EEPROM_SLAVE_WP_EN controls write protection.
REQ-029 With EEPROM_SLAVE_WP_EN defined: add input port WP (1 bit, after SDA). While WP=1, ACK_WDATA releases SDA (NACK), mem is unchanged, the pointer is unchanged, and the next state is WAIT_STOP. Control, address and read phases are unaffected.
REQ-030 With EEPROM_SLAVE_WP_EN undefined: there is no WP port and all writes are accepted.

Verification
REQ-031 Byte write then random read: write 0xA5 to address 0x123 (ctrl 0xA2, addr 0x23). Then ctrl 0xA2, addr 0x23, repeated START, ctrl 0xA3, read -> 0xA5, master NACK, STOP -> SDA released, BUSY=0.
REQ-032 Wrong device: ctrl 0xB0 -> no ACK (SDA=z on the 9th pulse); later bytes ignored; BUSY falls at STOP.
REQ-033 Sequential write with wrap: writes 0x11 and 0x22 starting at 0x7FF -> mem[0x7FF]=0x11 and mem[0x000]=0x22. A sequential read from 0x7FF with master ACK -> 0x11 then 0x22.
REQ-034 Abort: STOP after 4 data bits of a write to 0x010 (previously 0x5A) -> mem[0x010] still 0x5A; state IDLE.
REQ-035 Reset mid-read: RESET asserted while driving a 0 bit -> SDA=z within the same CLK cycle; pointer=0; a read after deassertion returns mem[0].
REQ-036 With EEPROM_SLAVE_WP_EN and WP=1: write of 0xFF to 0x040 -> data byte NACKed; a read of 0x040 returns its old value.
